// File: rtl/wb_arb_defs_pkg.sv
// Shared definitions for the Wishbone bus arbiters: FSM encodings,
// default sizing and the clog2 helper used for index/counter widths.
package wb_arb_defs;

  localparam int DEF_NM      = 4;
  localparam int DEF_DW      = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/wb_gpio_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester found
// searching upward from the slot after i_last, wrapping modulo NM.
module rr_pick
  import wb_arb_defs::*;
#(
  parameter int NM = DEF_NM,
  parameter int IW = (NM > 1) ? clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [IW-1:0] i_last,
  output logic [NM-1:0] o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int i = 1; i <= NM; i++) begin
      w_cand = (int'(i_last) + i) % NM;
      if (!o_valid && i_req[IW'(w_cand)]) begin
        o_valid             = 1'b1;
        o_gnt[IW'(w_cand)]  = 1'b1;
        o_idx               = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/wb_gpio_arbiter.sv
// Round-robin Wishbone arbiter sharing one GPIO slave between NM masters,
// with a watchdog that terminates cycles the slave never acknowledges.
module wb_gpio_arbiter
  import wb_arb_defs::*;
#(
  parameter int NM      = DEF_NM,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [DW-1:0]    s_dat_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i,
  output logic [NM-1:0]    gnt_o,
  output logic             busy_o
);

  localparam int IW = clog2(NM);
  localparam int CW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

  arb_state_t    r_state;
  arb_state_t    w_nextState;
  logic [NM-1:0] r_gnt;
  logic [IW-1:0] r_gntIdx;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_wdCnt;

  logic [NM-1:0] w_pickGnt;
  logic [IW-1:0] w_pickIdx;
  logic          w_pickValid;
  logic [DW-1:0] w_mDat [NM];
  logic          w_gCyc;
  logic          w_gStb;
  logic          w_gWe;
  logic [DW-1:0] w_gDat;
  logic          w_timeout;

  rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_gnt   (w_pickGnt),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  always_comb begin
    for (int k = 0; k < NM; k++) begin
      w_mDat[k] = m_dat_i[k*DW +: DW];
    end
  end

  assign w_gCyc = m_cyc_i[r_gntIdx];
  assign w_gStb = m_stb_i[r_gntIdx];
  assign w_gWe  = m_we_i[r_gntIdx];
  assign w_gDat = w_mDat[r_gntIdx];

  // A late ack on the expiry cycle still wins, so the error needs a stalled strobe.
  assign w_timeout = (TIMEOUT > 0) && (r_state == ST_BUSY) && w_gStb && !s_ack_i
                     && (r_wdCnt == CW'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_pickValid) w_nextState = ST_BUSY;
      ST_BUSY: begin
        if (!w_gCyc)        w_nextState = ST_IDLE;
        else if (w_timeout) w_nextState = ST_ERR;
      end
      ST_ERR:  if (!w_gCyc) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    case (r_state)
      ST_BUSY: begin
        s_cyc_o           = w_gCyc;
        s_stb_o           = w_gStb;
        s_we_o            = w_gWe;
        s_dat_o           = w_gDat;
        m_ack_o[r_gntIdx] = s_ack_i;
        m_err_o[r_gntIdx] = w_gCyc && w_timeout;
      end
      default: ;
    endcase
  end

  // Grant stays registered through ERR so the faulted master can be identified.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt    <= '0;
      r_gntIdx <= '0;
      r_last   <= IW'(NM - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pickValid) begin
            r_gnt    <= w_pickGnt;
            r_gntIdx <= w_pickIdx;
            r_last   <= w_pickIdx;
          end
        end
        ST_BUSY, ST_ERR: if (!w_gCyc) r_gnt <= '0;
        default: r_gnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != ST_BUSY || !w_gCyc || !w_gStb || s_ack_i || w_timeout) begin
      r_wdCnt <= '0;
    end else if (TIMEOUT > 0) begin
      r_wdCnt <= r_wdCnt + 1'b1;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = r_gnt;
  assign busy_o  = |r_gnt;

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Self-checking bench for wb_gpio_arbiter: table-driven vectors plus
// hand-written multi-cycle sequences, compared through a scoreboard queue.
module tb_wb_gpio_arbiter;

  typedef struct {
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        scyc;
    logic        sstb;
    logic        swe;
    logic [15:0] sdat;
    logic [15:0] mdat;
    logic        busy;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic [3:0]  we;
    logic        sack;
    logic [15:0] sdat;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  mCyc;
  logic [3:0]  mStb;
  logic [3:0]  mWe;
  logic [15:0] mDat [4];
  logic [63:0] mDatBus;
  logic [15:0] mDatOut;
  logic [3:0]  mAck;
  logic [3:0]  mErr;
  logic        sCyc;
  logic        sStb;
  logic        sWe;
  logic [15:0] sDatOut;
  logic [15:0] sDatIn;
  logic        sAck;
  logic [3:0]  gnt;
  logic        busy;

  int   checks;
  int   errors;
  exp_t expQ [$];
  vec_t tbl [$];

  assign mDatBus = {mDat[3], mDat[2], mDat[1], mDat[0]};

  wb_gpio_arbiter #(
    .NM      (4),
    .DW      (16),
    .TIMEOUT (15)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m_cyc_i (mCyc),
    .m_stb_i (mStb),
    .m_we_i  (mWe),
    .m_dat_i (mDatBus),
    .m_dat_o (mDatOut),
    .m_ack_o (mAck),
    .m_err_o (mErr),
    .s_cyc_o (sCyc),
    .s_stb_o (sStb),
    .s_we_o  (sWe),
    .s_dat_o (sDatOut),
    .s_dat_i (sDatIn),
    .s_ack_i (sAck),
    .gnt_o   (gnt),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // st: 0 idle, 1 busy (routing from master g), 2 err (grant g held, nothing routed)
  function automatic vec_t mk(input logic r, input logic [3:0] cyc, input logic [3:0] stb,
                              input logic [3:0] we, input logic sack, input int st,
                              input int g, input logic errBit);
    vec_t v;
    v.rst      = r;
    v.cyc      = cyc;
    v.stb      = stb;
    v.we       = we;
    v.sack     = sack;
    v.sdat     = 16'($urandom);
    v.exp.gnt  = (st == 0) ? 4'b0000 : 4'(1 << g);
    v.exp.busy = (st != 0);
    v.exp.mdat = v.sdat;
    v.exp.ack  = '0;
    v.exp.err  = '0;
    v.exp.scyc = 1'b0;
    v.exp.sstb = 1'b0;
    v.exp.swe  = 1'b0;
    v.exp.sdat = '0;
    if (st == 1) begin
      v.exp.scyc = cyc[g[1:0]];
      v.exp.sstb = stb[g[1:0]];
      v.exp.swe  = we[g[1:0]];
      v.exp.sdat = mDat[g[1:0]];
      if (sack)   v.exp.ack = 4'(1 << g);
      if (errBit) v.exp.err = 4'(1 << g);
    end
    return v;
  endfunction

  task automatic checkOutput(input string name);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got empty scoreboard, want one pending entry", name);
      return;
    end
    e = expQ.pop_front();
    if (gnt !== e.gnt || mAck !== e.ack || mErr !== e.err || sCyc !== e.scyc ||
        sStb !== e.sstb || sWe !== e.swe || sDatOut !== e.sdat || mDatOut !== e.mdat ||
        busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%b ack=%b err=%b cyc=%b stb=%b we=%b sdat=%h mdat=%h busy=%b, want gnt=%b ack=%b err=%b cyc=%b stb=%b we=%b sdat=%h mdat=%h busy=%b",
               name, gnt, mAck, mErr, sCyc, sStb, sWe, sDatOut, mDatOut, busy,
               e.gnt, e.ack, e.err, e.scyc, e.sstb, e.swe, e.sdat, e.mdat, e.busy);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(posedge clk);
    #1;
    rst    = v.rst;
    mCyc   = v.cyc;
    mStb   = v.stb;
    mWe    = v.we;
    sAck   = v.sack;
    sDatIn = v.sdat;
    expQ.push_back(v.exp);
    #3;
    checkOutput(name);
  endtask

  initial begin
    logic [3:0] keep;
    checks  = 0;
    errors  = 0;
    mDat[0] = 16'h00A5;
    mDat[1] = 16'h1111;
    mDat[2] = 16'h2222;
    mDat[3] = 16'h3333;
    rst     = 1'b1;
    mCyc    = '0;
    mStb    = '0;
    mWe     = '0;
    sAck    = 1'b0;
    sDatIn  = '0;
    repeat (2) @(posedge clk);

    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1, 0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1, 0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1, 0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0));
    // All four masters keep requesting; expected grant order 0,1,2,3,0.
    for (int n = 0; n < 5; n++) begin
      keep = 4'b1111 & ~4'(1 << (n % 4));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 4'b0101, 1'b0, 0, 0, 1'b0));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 4'b0101, 1'b1, 1, n % 4, 1'b0));
      tbl.push_back(mk(1'b0, keep, keep, 4'b0101, 1'b0, 1, n % 4, 1'b0));
    end

    foreach (tbl[i]) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    applyStimulus(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t3_rst");
    applyStimulus(mk(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 0, 0, 1'b0), "t3_idle");
    applyStimulus(mk(1'b0, 4'b0110, 4'b0110, 4'b0100, 1'b1, 1, 2, 1'b0), "t3_ack1");
    applyStimulus(mk(1'b0, 4'b0110, 4'b0010, 4'b0100, 1'b0, 1, 2, 1'b0), "t3_gap");
    applyStimulus(mk(1'b0, 4'b0110, 4'b0110, 4'b0100, 1'b1, 1, 2, 1'b0), "t3_ack2");
    applyStimulus(mk(1'b0, 4'b0110, 4'b0110, 4'b0100, 1'b1, 1, 2, 1'b0), "t3_ack3");
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1, 2, 1'b0), "t3_release");
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 0, 0, 1'b0), "t3_idleGap");
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1, 1, 1'b0), "t3_m1Gnt");
    applyStimulus(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 1, 1'b0), "t3_m1Rel");
    applyStimulus(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t3_end");

    applyStimulus(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t4_rst");
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 0, 0, 1'b0), "t4_idle");
    for (int i = 0; i < 15; i++)
      applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1, 1, 1'b0), $sformatf("t4_stall%0d", i));
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1, 1, 1'b1), "t4_err");
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 2, 1, 1'b0), "t4_lateAck");
    applyStimulus(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2, 1, 1'b0), "t4_errHold");
    applyStimulus(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2, 1, 1'b0), "t4_release");
    applyStimulus(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t4_end");

    applyStimulus(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t5_rst");
    applyStimulus(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 0, 1'b0), "t5_idle");
    for (int i = 0; i < 15; i++)
      applyStimulus(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1, 0, 1'b0), $sformatf("t5_stall%0d", i));
    applyStimulus(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1, 0, 1'b0), "t5_coincide");
    applyStimulus(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1, 0, 1'b0), "t5_stillBusy");
    applyStimulus(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 0, 1'b0), "t5_release");
    applyStimulus(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t5_end");

    applyStimulus(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0), "t6_rst");
    applyStimulus(mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 0, 0, 1'b0), "t6_idle");
    applyStimulus(mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1, 3, 1'b0), "t6_m3Gnt");
    applyStimulus(mk(1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1, 3, 1'b0), "t6_rstMid");
    applyStimulus(mk(1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b1, 0, 0, 1'b0), "t6_afterRst");
    applyStimulus(mk(1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b1, 1, 0, 1'b0), "t6_m0First");
    applyStimulus(mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1, 0, 1'b0), "t6_m0Rel");
    applyStimulus(mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 0, 0, 1'b0), "t6_idleGap");
    applyStimulus(mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1, 3, 1'b0), "t6_m3Next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
